// File: rtl/icache_refill_ctrl_if.sv
// Instruction-memory read bus between the icache refill controller and memory.
// One request is outstanding at a time; mem_rvalid completes it.
interface icache_refill_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss detection and line refill for the 2-way fetch-stage icache.
// Stalls fetch on a miss and reads the line one word at a time into a line buffer.
// It then strobes the assembled line into the cache for one cycle.
// A branch redirect (flush) abandons the refill, draining any outstanding request first.
// Optional build macro ICACHE_CRITICAL_WORD_FIRST_EN: the request order starts at the
// missed word and wraps. The buffer layout stays indexed by word address.
module icache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      pc,
  input  logic                             pc_valid,
  input  logic                             hit,
  input  logic                             flush,
  output logic                             stall,
  output logic                             fetch_enable,
  output logic [DATA_WIDTH*BLOCK_SIZE-1:0] fetch_data,
  output logic [31:0]                      miss_count,
  icache_refill_ctrl_if.master             mem
);

  localparam int WORD_BITS   = $clog2(BLOCK_SIZE);
  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int LINE_BITS   = 32 - OFFSET_BITS;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILL   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                           state;
  state_t                           state_next;
  logic [LINE_BITS-1:0]             line_addr;
  logic [WORD_BITS-1:0]             word_cnt;
  logic [WORD_BITS-1:0]             req_word;
  logic [DATA_WIDTH*BLOCK_SIZE-1:0] line_buf;
  logic                             miss;
  logic                             start_miss;
  logic                             take_word;
  logic                             mem_req_c;
  logic [31:0]                      mem_addr_c;
  logic                             unused_pc_bits;

  assign miss = pc_valid & ~hit & ~flush;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic [WORD_BITS-1:0] start_word;

  assign req_word       = start_word + word_cnt;
  assign unused_pc_bits = ^pc[1:0];

  // Remember which word missed so the refill begins with the critical word.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_word <= '0;
    end else if (start_miss) begin
      start_word <= pc[OFFSET_BITS-1:2];
    end
  end
`else
  assign req_word       = word_cnt;
  assign unused_pc_bits = ^pc[OFFSET_BITS-1:0];
`endif

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = mem_addr_c;
  assign fetch_data   = line_buf;

  // Next-state and output decode; DRAIN keeps the abandoned request alive until memory answers.
  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    mem_req_c    = 1'b0;
    mem_addr_c   = '0;
    fetch_enable = 1'b0;
    start_miss   = 1'b0;
    take_word    = 1'b0;
    case (state)
      IDLE: begin
        stall = miss;
        if (miss) begin
          start_miss = 1'b1;
          state_next = REFILL;
        end
      end
      REFILL: begin
        stall      = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = {line_addr, req_word, 2'b00};
        if (flush) begin
          state_next = mem.mem_rvalid ? IDLE : DRAIN;
        end else if (mem.mem_rvalid) begin
          take_word = 1'b1;
          if (word_cnt == LAST_WORD) begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        fetch_enable = 1'b1;
        state_next   = IDLE;
      end
      DRAIN: begin
        stall      = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = {line_addr, req_word, 2'b00};
        if (mem.mem_rvalid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, miss bookkeeping and line-buffer assembly; reset discards any partial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_addr  <= '0;
      word_cnt   <= '0;
      line_buf   <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      if (start_miss) begin
        line_addr  <= pc[31:OFFSET_BITS];
        word_cnt   <= '0;
        miss_count <= miss_count + 32'd1;
      end
      if (take_word) begin
        line_buf[int'(req_word)*DATA_WIDTH +: DATA_WIDTH] <= mem.mem_rdata;
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss/refill controller for the 2-way instruction cache in the fetch stage. It detects a miss on the fetch address and stalls the fetch stage. It then reads the 4-word line from instruction memory one word per transaction, assembles it into a 128-bit buffer, and presents it to the cache as a single-cycle `fetch_enable` pulse with `fetch_data`. It also handles branch-redirect flushes mid-refill and counts misses.

## Interface
- `DATA_WIDTH`, 32, word width
- `BLOCK_SIZE`, 4, words per cache line
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `pc`  in  32  fetch address presented to the cache
- `pc_valid`  in  1  fetch stage holds a valid request this cycle
- `hit`  in  1  cache hit for `pc` (combinational from cache)
- `flush`  in  1  branch redirect; abandon current miss
- `stall`  out  1  freeze PC and fetch/decode register
- `mem_req`  out  1  word read request pending
- `mem_addr`  out  32  word-aligned read address
- `mem_rvalid`  in  1  read data valid; completes the pending request
- `mem_rdata`  in  32  read data
- `fetch_enable`  out  1  line-fill strobe to cache, one cycle
- `fetch_data`  out  128  assembled line; word i at bits [32i +: 32]
- `miss_count`  out  32  number of refills started since reset

## Operation
- States: IDLE, REFILL, FILL, DRAIN.
- IDLE
  - Miss = `pc_valid & !hit & !flush`.
  - On miss: latch `line_addr = pc[31:4]`, latch `start = pc[3:2]`, clear word counter, increment `miss_count` (wraps at 2^32), go to REFILL.
- REFILL
  - `mem_req=1`, `mem_addr = {line_addr, word, 2'b00}`; address held stable until `mem_rvalid`.
  - On `mem_rvalid`: write `mem_rdata` into buffer slot `word`, counter+1.
  - The next request may issue in the following cycle with no bubble.
  - After the 4th word, go to FILL.
- FILL
  - `fetch_enable=1`, `mem_req=0`, `stall=0`; the cache forwards the requested word and writes the line this cycle.
  - Go to IDLE.
- Flush in REFILL
  - If `mem_rvalid` is high in the same cycle, go to IDLE.
  - Otherwise go to DRAIN: hold `mem_req`/`mem_addr` until `mem_rvalid`, then go to IDLE.
  - Flushed data is never filled; no FILL pulse.
- `flush` in FILL or DRAIN is ignored.
- `mem_rvalid` while `mem_req=0` is ignored.
- `stall = (IDLE & miss) | REFILL | DRAIN`.
- Word order (default): 0,1,2,3.
- Only one memory request is ever outstanding.

## Timing
- Reset values: state IDLE; `stall=0`, `mem_req=0`, `mem_addr=0`, `fetch_enable=0`, `fetch_data=0`, `miss_count=0`.
- Reset mid-refill aborts immediately. Buffer contents are discarded, no FILL pulse. Late `mem_rvalid` is ignored.
- Miss seen in IDLE at cycle T:
  - `stall` high at T (combinational).
  - `mem_req` high from T+1.
- With `mem_rvalid` same-cycle (zero-wait memory):
  - Words return T+1..T+4.
  - FILL at T+5, `stall` low at T+5.
  - IDLE at T+6. Total stall: 5 cycles.
- With N wait cycles per word: FILL at T+1+4(N+1).
- `fetch_data` is stable from FILL until the next REFILL starts.
- `miss_count` updates at T+1.

## Configuration
- `ICACHE_CRITICAL_WORD_FIRST_EN`
- Defined: request order starts at `start` and wraps modulo 4 (`start`=2 gives 2,3,0,1). Buffer slot is still indexed by word address, so the `fetch_data` layout is unchanged. Latency is unchanged.
- Undefined: order is always 0,1,2,3; `start` is unused.

## Test plan
- Reset: assert `rst` during REFILL after 2 words, `pc_valid=0` -> next cycle state IDLE, `mem_req=0`, `stall=0`, `miss_count=0`, no `fetch_enable`.
- Cold miss, `pc=0x0000_0124`, zero-wait memory returning `0xA0+i` for word i -> `mem_addr` 0x120, 0x124, 0x128, 0x12C on T+1..T+4. At T+5: `fetch_enable=1`, `fetch_data=0x000000A3_000000A2_000000A1_000000A0`, `stall=0`. `miss_count=1`.
- Hit path, `hit=1`, `pc_valid=1` for 10 cycles -> `stall=0`, `mem_req=0` throughout.
- Wait states, `mem_rvalid` 2 cycles after each request, miss at T -> FILL at T+13, `stall` high T..T+12.
- Flush at the 2nd word with `mem_rvalid` low -> DRAIN holds `mem_addr=0x124` until `rvalid`, then IDLE. No `fetch_enable`. A new miss at `pc=0x400` then refills 0x400-0x40C.
- With `ICACHE_CRITICAL_WORD_FIRST_EN`, `pc=0x0000_0128` -> `mem_addr` order 0x128, 0x12C, 0x120, 0x124. `fetch_data` layout identical to the non-macro case.
